mod_i2c_arbiter: RTL and testbench
==================================

// Module: mod_i2c_arbiter
// PURPOSE
// - Round-robin arbiter/sequencer sharing one I2C master among N requesters.
// - Latches the winner's transaction fields, fires the master start pulse, tracks the master
//   ready bit, and returns read data and completion to the winning requester only.
// - One transaction per grant. The next grant is issued only after the master reports ready.
// PARAMETERS
// - N            4     number of requesters, 2..8
// - TIMEOUT_CYC  4000  clk cycles allowed per transaction before abort; only with I2C_ARB_TIMEOUT_EN
// PORTS
// - clk        in   1    system clock, 16 MHz
// - rst        in   1    asynchronous, active-low reset
// - req        in   N    request per requester; hold high, fields stable, until own done pulse
// - req_rw     in   N    per requester: 1 = read, 0 = write
// - req_speed  in   N    per requester: 0 = 100 kbps, 1 = 400 kbps
// - req_addr   in   7*N  7-bit slave address; requester i uses [7i+6:7i]
// - req_wdata  in   8*N  write byte; requester i uses [8i+7:8i]
// - gnt        out  N    one-hot grant; high from issue through the done cycle
// - done       out  N    1-cycle completion pulse to the granted requester
// - err        out  1    high with done when the transaction timed out
// - rdata      out  8    read byte; valid while done is high; holds until the next done
// - m_start    out  1    1-cycle start pulse to the I2C master
// - m_rst      out  1    1-cycle reset pulse to the I2C master (timeout abort)
// - m_rw, m_speed, m_addr[6:0], m_wdata[7:0]  out  transaction fields; latched, stable while gnt
// - m_ready    in   1    master ready bit: 1 = idle
// - m_rdata    in   8    master read data
// BEHAVIOUR
// - Reset (rst = 0, async): state IDLE; rr_ptr = 0; every output = 0.
//   - Aborts any transaction in flight. No done pulse is issued.
// - States: IDLE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
// - IDLE, at an edge where |req && m_ready:
//   - Winner = first set req bit searching upward from rr_ptr, wrapping N-1 -> 0.
//   - gnt <= onehot(winner); latch m_* fields from the winner; m_start <= 1; go to WAIT_BUSY.
//   - gnt and m_start rise 1 cycle after req is sampled.
//   - If m_ready = 0, wait in IDLE.
// - WAIT_BUSY:
//   - m_start <= 0 on the next edge, so the pulse is exactly 1 cycle.
//   - When m_ready = 0, go to WAIT_DONE.
// - WAIT_DONE: when m_ready = 1:
//   - rdata <= m_rdata (read transactions only; writes leave rdata unchanged).
//   - done[winner] <= 1; err <= 0; rr_ptr <= (winner + 1) mod N; go to RESP.
// - RESP (1 cycle):
//   - done and gnt clear at the exit edge; req is ignored during RESP.
//   - The requester must drop req during its done cycle; a req still high in IDLE is a new request.
// - Fairness: the winner is the lowest priority next round. Simultaneous requests are granted in
//   rr_ptr order. No requester waits more than N-1 transactions.
// - Requests changing while gnt is high do not affect the latched m_* fields.
// - Pointer arithmetic: 3-bit index with explicit wrap at N-1, not a power-of-2 mask.
// CONFIGURATION
// - I2C_ARB_TIMEOUT_EN defined:
//   - A 16-bit counter clears at issue and increments in WAIT_BUSY and WAIT_DONE.
//   - At count == TIMEOUT_CYC-1: m_rst <= 1 for 1 cycle; done[winner] <= 1 and err <= 1;
//     rdata unchanged; rr_ptr advances; go to RESP.
//   - Completion and timeout on the same edge: completion wins, err = 0.
// - I2C_ARB_TIMEOUT_EN undefined:
//   - No counter. A hung master stalls the arbiter indefinitely.
//   - err and m_rst are tied 0.
// TESTING
// - Single write: req[1]=1, addr 0x50, wdata 0xA5; master model drops ready for 20 cycles.
//   -> gnt=0010; m_start pulses 1 cycle with m_addr=0x50, m_wdata=0xA5, m_rw=0;
//      done[1] pulses 1 cycle after ready rises; err=0.
// - Read: req[2] with rw=1; master returns 0x3C.
//   -> rdata=0x3C while done[2]=1; rdata holds 0x3C after done drops.
// - Contention: req=1111 held (each requester re-requests after its done).
//   -> grant order 0,1,2,3,0; never two gnt bits high at once.
// - Wrap: rr_ptr=3 after serving requester 2; req=1001 simultaneously.
//   -> requester 3 first, then 0; rr_ptr returns to 1.
// - Timeout (macro on, TIMEOUT_CYC=100): master never returns ready.
//   -> 100 cycles after issue: m_rst=1 for 1 cycle, done and err pulse together, IDLE resumes.
// - Async reset: rst low mid WAIT_DONE.
//   -> immediately gnt=0, m_start=0, done=0; after release req[0] is granted first.

Source files
------------

// File: rtl/mod_i2c_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master among N requesters.
// Latency: gnt/m_start one cycle after req is sampled in IDLE; done one cycle after m_ready returns.
// Backpressure: no grant while the master is not ready; requesters hold req until their done pulse.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_i/req_rw_i/req_speed_i [N]     per-requester request, direction (1=read), speed (1=400k)
//   req_addr_i [7N], req_wdata_i [8N]  per-requester slave address and write byte
//   gnt_o, done_o [N]                  one-hot grant, one-cycle completion pulse
//   err_o, rdata_o                     timeout flag (with done), last read byte
//   m_start_o, m_rst_o                 one-cycle start / abort pulses to the master
//   m_rw_o, m_speed_o, m_addr_o, m_wdata_o  latched transaction fields
//   m_ready_i, m_rdata_i               master idle flag and read data
//
// Build option: define I2C_ARB_TIMEOUT_EN to enable the per-transaction timeout
// (TIMEOUT_CYC parameter). Without it err_o and m_rst_o are tied low.
module mod_i2c_arbiter #(
    parameter int N = 4
`ifdef I2C_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4000
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     req_rw_i,
    input  logic [N-1:0]     req_speed_i,
    input  logic [7*N-1:0]   req_addr_i,
    input  logic [8*N-1:0]   req_wdata_i,
    output logic [N-1:0]     gnt_o,
    output logic [N-1:0]     done_o,
    output logic             err_o,
    output logic [7:0]       rdata_o,
    output logic             m_start_o,
    output logic             m_rst_o,
    output logic             m_rw_o,
    output logic             m_speed_o,
    output logic [6:0]       m_addr_o,
    output logic [7:0]       m_wdata_o,
    input  logic             m_ready_i,
    input  logic [7:0]       m_rdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t       state_q, state_d;
    logic [2:0]   rr_ptr_q, rr_ptr_d;
    logic [2:0]   win_q, win_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [N-1:0] done_q, done_d;
    logic [7:0]   rdata_q, rdata_d;
    logic         m_start_q, m_start_d;
    logic         m_rw_q, m_rw_d;
    logic         m_speed_q, m_speed_d;
    logic [6:0]   m_addr_q, m_addr_d;
    logic [7:0]   m_wdata_q, m_wdata_d;

    // Inputs padded to the 8-requester maximum so a 3-bit index selects cleanly.
    logic [7:0]   req_pad, rw_pad, spd_pad;
    logic [55:0]  addr_pad;
    logic [63:0]  wdata_pad;
    assign req_pad   = 8'(req_i);
    assign rw_pad    = 8'(req_rw_i);
    assign spd_pad   = 8'(req_speed_i);
    assign addr_pad  = 56'(req_addr_i);
    assign wdata_pad = 64'(req_wdata_i);

    // Round-robin search: offsets scanned from farthest to nearest so the
    // requester closest to rr_ptr (upward, wrapping at N-1) is the last write.
    logic       win_found;
    logic [2:0] win_idx;
    logic [3:0] sum;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + 4'(k);
            if (sum >= 4'(N)) sum = sum - 4'(N);
            if (req_pad[sum[2:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[2:0];
            end
        end
    end

    logic [2:0] next_ptr;
    assign next_ptr = (win_q == 3'(N - 1)) ? 3'd0 : win_q + 3'd1;

    logic tmo_hit;
    logic fire_abort;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        m_rst_q, m_rst_d;
    assign tmo_hit = (cnt_q == 16'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        rdata_d    = rdata_q;
        m_start_d  = 1'b0;
        m_rw_d     = m_rw_q;
        m_speed_d  = m_speed_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        fire_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found && m_ready_i) begin
                    win_d = win_idx;
                    for (int j = 0; j < N; j++) gnt_d[j] = (3'(j) == win_idx);
                    m_rw_d    = rw_pad[win_idx];
                    m_speed_d = spd_pad[win_idx];
                    m_addr_d  = addr_pad[6'(win_idx) * 6'd7 +: 7];
                    m_wdata_d = wdata_pad[{win_idx, 3'b000} +: 8];
                    m_start_d = 1'b1;
                    state_d   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tmo_hit) fire_abort = 1'b1;
                else if (!m_ready_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Completion takes priority over a timeout on the same edge.
                if (m_ready_i) begin
                    if (m_rw_q) rdata_d = m_rdata_i;
                    done_d   = gnt_q;
                    rr_ptr_d = next_ptr;
                    state_d  = RESP;
                end else if (tmo_hit) begin
                    fire_abort = 1'b1;
                end
            end
            RESP: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fire_abort) begin
            done_d   = gnt_q;
            rr_ptr_d = next_ptr;
            state_d  = RESP;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_comb begin
        err_d   = fire_abort;
        m_rst_d = fire_abort;
        if (state_q == WAIT_BUSY || state_q == WAIT_DONE) cnt_d = cnt_q + 16'd1;
        else                                               cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            m_rst_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            m_rst_q <= m_rst_d;
        end
    end

    assign err_o   = err_q;
    assign m_rst_o = m_rst_q;
`else
    assign err_o   = 1'b0;
    assign m_rst_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            m_start_q <= 1'b0;
            m_rw_q    <= 1'b0;
            m_speed_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            m_start_q <= m_start_d;
            m_rw_q    <= m_rw_d;
            m_speed_q <= m_speed_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign m_start_o = m_start_q;
    assign m_rw_o    = m_rw_q;
    assign m_speed_o = m_speed_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;

endmodule

// File: tb/tb_mod_i2c_arbiter.sv
// Testbench for mod_i2c_arbiter: directed vector table plus hand-written
// sequences for contention, asynchronous reset and (when built with
// I2C_ARB_TIMEOUT_EN) the transaction timeout.
module tb_mod_i2c_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_i, req_rw_i, req_speed_i;
    logic [27:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  gnt_o, done_o;
    logic        err_o;
    logic [7:0]  rdata_o;
    logic        m_start_o, m_rst_o, m_rw_o, m_speed_o;
    logic [6:0]  m_addr_o;
    logic [7:0]  m_wdata_o;
    logic        m_ready_i;
    logic [7:0]  m_rdata_i;

    int          tests = 0;
    int          fails = 0;
    int          busy_len = 1;
    bit          hang = 1'b0;
    logic [7:0]  slv_data = 8'h00;

    mod_i2c_arbiter #(
        .N(4)
`ifdef I2C_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req_i), .req_rw_i(req_rw_i), .req_speed_i(req_speed_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .m_start_o(m_start_o), .m_rst_o(m_rst_o), .m_rw_o(m_rw_o), .m_speed_o(m_speed_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_ready_i(m_ready_i), .m_rdata_i(m_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Never more than one grant at a time.
    always @(negedge clk) begin
        if (rst_n) chk("gnt_onehot", 32'($onehot0(gnt_o)), 32'd1);
    end

    // Master model: after a start pulse, ready drops for busy_len cycles
    // (or until an abort / reset when hung), then returns with slv_data.
    initial begin
        m_ready_i = 1'b1;
        m_rdata_i = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (m_start_o) begin
                m_ready_i = 1'b0;
                for (int c = 0; c < (hang ? 100000 : busy_len); c++) begin
                    @(posedge clk); #1;
                    if (!rst_n || m_rst_o) break;
                end
                m_rdata_i = slv_data;
                m_ready_i = 1'b1;
            end
        end
    end

    function automatic void set_fields();
        for (int i = 0; i < 4; i++) begin
            req_addr_i[7*i +: 7]  = 7'h4F + 7'(i);
            req_wdata_i[8*i +: 8] = 8'hA4 + 8'(i);
        end
        req_rw_i    = 4'b0100;
        req_speed_i = 4'b1010;
    endfunction

    // One complete transaction: requests in mask, expected winner egnt.
    task automatic run_txn(input logic [3:0] mask, input logic [7:0] sdat, input int busy,
                           input logic [3:0] egnt, input logic [7:0] erd, input bit perturb);
        int w;
        int widx;
        widx = 0;
        for (int j = 0; j < 4; j++) if (egnt[j]) widx = j;
        slv_data = sdat;
        busy_len = busy;
        req_i    = mask;
        w = 0;
        do begin @(negedge clk); w++; end while (!m_start_o && w < 50);
        chk("issue_latency", 32'(w), 32'd1);
        chk("gnt_at_start", 32'(gnt_o), 32'(egnt));
        chk("m_addr", 32'(m_addr_o), 32'(7'h4F + 7'(widx)));
        chk("m_wdata", 32'(m_wdata_o), 32'(8'hA4 + 8'(widx)));
        chk("m_rw", 32'(m_rw_o), 32'(widx == 2));
        chk("m_speed", 32'(m_speed_o), 32'(widx % 2));
        if (perturb) begin
            req_addr_i  = ~req_addr_i;
            req_wdata_i = ~req_wdata_i;
            req_rw_i    = ~req_rw_i;
            req_speed_i = ~req_speed_i;
        end
        @(negedge clk);
        chk("m_start_pulse", 32'(m_start_o), 32'd0);
        w = 1;
        while (done_o == 4'b0 && w < busy + 50) begin @(negedge clk); w++; end
        chk("done_latency", 32'(w), 32'(busy + 1));
        chk("done_vec", 32'(done_o), 32'(egnt));
        chk("gnt_at_done", 32'(gnt_o), 32'(egnt));
        chk("err_at_done", 32'(err_o), 32'd0);
        chk("rdata_at_done", 32'(rdata_o), 32'(erd));
        chk("m_addr_stable", 32'(m_addr_o), 32'(7'h4F + 7'(widx)));
        chk("m_wdata_stable", 32'(m_wdata_o), 32'(8'hA4 + 8'(widx)));
        req_i = mask & ~egnt;
        set_fields();
        @(negedge clk);
        chk("done_cleared", 32'(done_o), 32'd0);
        chk("gnt_cleared", 32'(gnt_o), 32'd0);
        chk("rdata_hold", 32'(rdata_o), 32'(erd));
    endtask

    typedef struct {
        logic [3:0] req;
        logic [7:0] sdat;
        int         busy;
        logic [3:0] egnt;
        logic [7:0] erd;
        bit         perturb;
    } vec_t;

    vec_t vt[10];

    initial begin
        int w;
        // single write, read, wrap 3->0, contention order, sparse masks
        vt[0] = '{4'b0010, 8'h11, 20, 4'b0010, 8'h00, 1'b0};
        vt[1] = '{4'b0100, 8'h3C,  5, 4'b0100, 8'h3C, 1'b0};
        vt[2] = '{4'b1001, 8'h22,  3, 4'b1000, 8'h3C, 1'b1};
        vt[3] = '{4'b1001, 8'h33,  1, 4'b0001, 8'h3C, 1'b0};
        vt[4] = '{4'b1111, 8'h44,  2, 4'b0010, 8'h3C, 1'b0};
        vt[5] = '{4'b1111, 8'h77,  7, 4'b0100, 8'h77, 1'b1};
        vt[6] = '{4'b1111, 8'h55,  1, 4'b1000, 8'h77, 1'b0};
        vt[7] = '{4'b1111, 8'h66,  4, 4'b0001, 8'h77, 1'b0};
        vt[8] = '{4'b0001, 8'h88,  2, 4'b0001, 8'h77, 1'b0};
        vt[9] = '{4'b1100, 8'h9E,  6, 4'b0100, 8'h9E, 1'b0};

        rst_n = 1'b0;
        req_i = 4'b0;
        set_fields();
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        chk("rst_m_start", 32'(m_start_o), 32'd0);
        chk("rst_m_rst", 32'(m_rst_o), 32'd0);
        chk("rst_m_addr", 32'(m_addr_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++)
            run_txn(vt[v].req, vt[v].sdat, vt[v].busy, vt[v].egnt, vt[v].erd, vt[v].perturb);

        // Contention: all four held, each re-requests after its done.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        slv_data = 8'h5A;
        busy_len = 3;
        req_i    = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (!m_start_o && w < 50) begin @(negedge clk); w++; end
            chk("contend_gnt", 32'(gnt_o), 32'(4'b0001 << (g % 4)));
            w = 0;
            while (done_o == 4'b0 && w < 50) begin @(negedge clk); w++; end
            chk("contend_done", 32'(done_o), 32'(4'b0001 << (g % 4)));
            req_i = 4'b1111 & ~done_o;
            @(negedge clk);
            req_i = 4'b1111;
        end
        w = 0;
        while (done_o == 4'b0 && w < 50) begin @(negedge clk); w++; end
        req_i = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of WAIT_DONE.
        busy_len = 30;
        req_i    = 4'b0100;
        w = 0;
        while (!m_start_o && w < 50) begin @(negedge clk); w++; end
        chk("pre_rst_gnt", 32'(gnt_o), 32'(4'b0100));
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt_o), 32'd0);
        chk("arst_m_start", 32'(m_start_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_m_addr", 32'(m_addr_o), 32'd0);
        req_i = 4'b1111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(4'b1111, 8'hEE, 2, 4'b0001, 8'h00, 1'b0);
        req_i = 4'b0000;
        @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
        // Hung master: abort after TIMEOUT_CYC cycles, then normal service resumes.
        hang  = 1'b1;
        req_i = 4'b0001;
        w = 0;
        while (!m_start_o && w < 50) begin @(negedge clk); w++; end
        chk("tmo_gnt", 32'(gnt_o), 32'(4'b0001));
        w = 0;
        while (!m_rst_o && w < 300) begin @(negedge clk); w++; end
        chk("tmo_cycles", 32'(w), 32'd100);
        chk("tmo_done", 32'(done_o), 32'(4'b0001));
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_rdata", 32'(rdata_o), 32'd0);
        req_i = 4'b0000;
        hang  = 1'b0;
        @(negedge clk);
        chk("tmo_m_rst_pulse", 32'(m_rst_o), 32'd0);
        chk("tmo_err_pulse", 32'(err_o), 32'd0);
        chk("tmo_done_pulse", 32'(done_o), 32'd0);
        chk("tmo_gnt_clear", 32'(gnt_o), 32'd0);
        @(negedge clk);
        run_txn(4'b0010, 8'h12, 3, 4'b0010, 8'h00, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
